mdio_responder: RTL
===================

# mdio_responder

Clause-22 MDIO management responder: the PHY end of the MDC/MDD link that the FTop management master drives. It oversamples MDC on the 200 MHz system clock, decodes read and write frames addressed to its PHY address, and serves a 32×16 register file that fabric logic can also access through a local port. It is used to emulate a PHY management plane for loopback bring-up of the GMII/MDIO path and for simulation of the KC705 top level.

## Interface
- PHY_ADDR, 5'd1, PHY address this responder answers to.
- PHY_ID, 32'h0141_0CC2, reset/fixed contents of registers 2 (bits 31:16) and 3 (bits 15:0); both are read-only.
- sys0_clk  in  1  system clock, 200 MHz; all logic is on this clock.
- sys0_rstn  in  1  reset, asynchronous assert, active-low.
- mdc  in  1  MDIO clock from master, asynchronous to sys0_clk, ≤2.5 MHz.
- mdd_i  in  1  MDIO data from pad.
- mdd_o  out  1  MDIO data to pad.
- mdd_oe  out  1  pad output enable; 1 = responder drives.
- lcl_addr  in  5  local register address.
- lcl_we  in  1  local write strobe.
- lcl_wdata  in  16  local write data.
- lcl_rdata  out  16  registered read of lcl_addr.
- mdio_wr  out  1  one-cycle pulse on each accepted MDIO write.
- mdio_rd  out  1  one-cycle pulse on each accepted MDIO read.
- mdio_regad  out  5  register address of the last accepted frame.

## Operation
- mdc and mdd_i pass through 2-FF synchronizers; a third mdc register forms a rising-edge strobe (rise). All bit processing happens on rise, using synchronized mdd_i.
- FSM states: PRE, ST, OP, PHYAD, REGAD, TA, DATA.
- PRE: preamble counter (6 bits, saturates at 32) increments on each sampled 1 and clears on each sampled 0. A 0 sampled with count ≥ threshold (32) enters ST; otherwise it stays in PRE.
- ST: expects a 1; otherwise go to PRE with count 0.
- OP: two bits; 10 = read, 01 = write; 00/11 go to PRE with count 0.
- PHYAD, REGAD: 5 bits each, MSB first. A PHYAD mismatch sets a local ignore flag: the frame is tracked to its end, but nothing is driven or written.
- TA, read and matched: mdd_oe rises with mdd_o = 0 for the second TA bit. Register data is latched at the first TA bit.
- TA, write: both bits are ignored, and no TA value check is made.
- DATA, read: drive 16 bits MSB first. Release the pad (mdd_oe = 0) on the rise that follows bit 0.
- DATA, write: shift in 16 bits. On the 16th bit, write the register (unless ignored or address 2/3) and pulse mdio_wr.
- Leaving DATA: return to PRE with count 0.
- mdio_rd pulses at the second TA bit of a matched read. mdio_regad updates whenever either strobe pulses.
- Local port: a lcl_we write takes effect at the clock edge. Writes to addresses 2/3 are ignored. lcl_rdata is the registered value at lcl_addr.
- Simultaneous MDIO and local write to the same address: the local write wins.
- Reset values:
  - mdd_oe = 0, mdd_o = 0, lcl_rdata = 0, mdio_wr = 0, mdio_rd = 0, mdio_regad = 0.
  - Register file all zero, except registers 2/3 = PHY_ID.
  - FSM in PRE with count 0.
- Reset asserted mid-frame releases the pad within the reset itself (asynchronous).

## Timing
- Latency from an MDC rising edge at the pin to the rise strobe: 3 sys0_clk cycles.
- mdd_o/mdd_oe update 1 cycle after rise, so 4 cycles (20 ns) after the MDC edge. This is well inside the 300 ns clock-to-out budget.
- mdio_wr and mdio_rd assert 1 cycle after the qualifying rise.
- lcl_rdata has 1-cycle read latency. A same-cycle local write is visible on the next cycle's read.
- Glitches on MDC shorter than 2 sys0_clk cycles are not required to be filtered.

## Configuration
- MDIO_RESP_PRESUP_EN
  - Defined: after the first completed matched frame since reset, the preamble threshold drops from 32 to 1 (preamble suppression).
  - Undefined: the threshold is always 32.

## Structure
- Shared package mdio_pkg:
  - FSM state enum.
  - OP codes OP_RD = 2'b10 and OP_WR = 2'b01.
  - Constants PRE_LEN = 32 and ID register addresses 2/3.
- One sub-module, mdio_sync_edge: 2-FF synchronizer for mdc/mdd_i plus the rise strobe.

## Test plan
- Write, PHYAD 1, REGAD 0, data 16'hA5C3: mdio_wr pulses and mdio_regad = 0. lcl_addr = 0 then returns A5C3, and mdd_oe stays 0 throughout.
- Read of REGAD 2: second TA bit is 0, data bits are 16'h0141, and mdd_oe drops after bit 0. Read of REGAD 3 returns 0CC2.
- Write 16'hFFFF to REGAD 3, then read it: still 0CC2 and no register change. mdio_wr still pulses.
- Write with PHYAD 5: no mdio_wr, no register change, mdd_oe stays 0.
- Preamble of 31 ones followed by a valid frame: frame ignored. With 32 ones it is accepted.
  - With MDIO_RESP_PRESUP_EN: a second frame with a 1-bit preamble is accepted.
  - Without the macro: that frame is ignored.
- Reset pulse in the middle of a read's DATA phase: mdd_oe goes to 0 immediately. Afterwards, a full-preamble frame is required and succeeds.

Source files
------------

// File: rtl/mdio_pkg.sv
// mdio_pkg -- shared definitions for the Clause-22 MDIO responder.
//   mdio_state_e : frame decoder states
//   OP_RD/OP_WR  : Clause-22 opcode values
//   PRE_LEN      : preamble length (ones) required before a start pattern
//   ID_HI_ADDR/ID_LO_ADDR : read-only PHY identifier registers
//   is_id_reg()  : true for either identifier register address
`timescale 1ns/1ps
package mdio_pkg;

  typedef enum logic [2:0] {
    S_PRE,
    S_ST,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_DATA
  } mdio_state_e;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  localparam int unsigned PRE_LEN = 32;

  localparam logic [4:0] ID_HI_ADDR = 5'd2;
  localparam logic [4:0] ID_LO_ADDR = 5'd3;

  function automatic logic is_id_reg(input logic [4:0] addr);
    return (addr == ID_HI_ADDR) || (addr == ID_LO_ADDR);
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge -- brings MDC/MDD into the system clock domain.
//   clk_i, rst_ni : system clock, async active-low reset
//   mdc_i, mdd_i  : raw pad signals (asynchronous)
//   rise_o        : one-cycle strobe, 3 clk_i cycles after an MDC rising edge
//   mdd_o         : synchronized MDD, aligned with rise_o
`timescale 1ns/1ps
module mdio_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mdc_i,
  input  logic mdd_i,
  output logic rise_o,
  output logic mdd_o
);

  logic [1:0] mdc_sync_q;
  logic       mdc_dly_q;
  logic       rise_q;
  logic [1:0] mdd_sync_q;
  logic       mdd_q;

  // Strobe and data are both registered once more so they stay aligned.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdc_sync_q <= '0;
      mdc_dly_q  <= 1'b0;
      rise_q     <= 1'b0;
      mdd_sync_q <= '0;
      mdd_q      <= 1'b0;
    end else begin
      mdc_sync_q <= {mdc_sync_q[0], mdc_i};
      mdc_dly_q  <= mdc_sync_q[1];
      rise_q     <= mdc_sync_q[1] & ~mdc_dly_q;
      mdd_sync_q <= {mdd_sync_q[0], mdd_i};
      mdd_q      <= mdd_sync_q[1];
    end
  end

  assign rise_o = rise_q;
  assign mdd_o  = mdd_q;

endmodule

// File: rtl/mdio_responder.sv
// mdio_responder -- Clause-22 MDIO PHY-side responder with a 32x16 register
// file shared with a local fabric port.
//   sys0_clk, sys0_rstn : 200 MHz system clock, async active-low reset
//   mdc, mdd_i          : MDIO clock and data from the pad
//   mdd_o, mdd_oe       : MDIO data to the pad and its output enable
//   lcl_addr/we/wdata   : local register write port
//   lcl_rdata           : registered read of lcl_addr (1-cycle latency)
//   mdio_wr, mdio_rd    : one-cycle pulses per accepted MDIO write / read
//   mdio_regad          : register address of the last accepted frame
// Build option: define MDIO_RESP_PRESUP_EN to enable preamble suppression
// (threshold drops to 1 after the first completed matched frame).
`timescale 1ns/1ps
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [31:0] PHY_ID   = 32'h0141_0CC2
) (
  input  logic        sys0_clk,
  input  logic        sys0_rstn,
  input  logic        mdc,
  input  logic        mdd_i,
  output logic        mdd_o,
  output logic        mdd_oe,
  input  logic [4:0]  lcl_addr,
  input  logic        lcl_we,
  input  logic [15:0] lcl_wdata,
  output logic [15:0] lcl_rdata,
  output logic        mdio_wr,
  output logic        mdio_rd,
  output logic [4:0]  mdio_regad
);

  import mdio_pkg::*;

  logic rise;
  logic bit_in;

  mdio_sync_edge u_sync (
    .clk_i  (sys0_clk),
    .rst_ni (sys0_rstn),
    .mdc_i  (mdc),
    .mdd_i  (mdd_i),
    .rise_o (rise),
    .mdd_o  (bit_in)
  );

  mdio_state_e state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  phyad_q, phyad_d;
  logic [4:0]  regad_q, regad_d;
  logic        op_hi_q, op_hi_d;
  logic        is_rd_q, is_rd_d;
  logic        ignore_q, ignore_d;
  logic        oe_q, oe_d;
  logic        dout_q, dout_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [4:0]  regad_out_q, regad_out_d;
  logic [15:0] regs_q [32];
  logic [15:0] regs_d [32];
  logic [15:0] lcl_rdata_q, lcl_rdata_d;
  logic        mdio_we;
  logic [15:0] mdio_wdata;
  logic [5:0]  pre_thr;

`ifdef MDIO_RESP_PRESUP_EN
  logic presup_q, presup_d;
  assign pre_thr = presup_q ? 6'd1 : 6'(PRE_LEN);
`else
  assign pre_thr = 6'(PRE_LEN);
`endif

  // Frame decoder: all bit processing is gated by the rise strobe.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    phyad_d     = phyad_q;
    regad_d     = regad_q;
    op_hi_d     = op_hi_q;
    is_rd_d     = is_rd_q;
    ignore_d    = ignore_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    regad_out_d = regad_out_q;
    mdio_we     = 1'b0;
    mdio_wdata  = {shift_q[14:0], bit_in};
`ifdef MDIO_RESP_PRESUP_EN
    presup_d    = presup_q;
`endif
    if (rise) begin
      unique case (state_q)
        S_PRE: begin
          if (bit_in) begin
            if (pre_cnt_q < 6'(PRE_LEN)) pre_cnt_d = pre_cnt_q + 6'd1;
          end else if (pre_cnt_q >= pre_thr) begin
            state_d   = S_ST;
            pre_cnt_d = '0;
          end else begin
            pre_cnt_d = '0;
          end
        end
        S_ST: begin
          bit_cnt_d = '0;
          if (bit_in) begin
            state_d = S_OP;
          end else begin
            state_d   = S_PRE;
            pre_cnt_d = '0;
          end
        end
        S_OP: begin
          if (bit_cnt_q == 4'd0) begin
            op_hi_d   = bit_in;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = '0;
            case ({op_hi_q, bit_in})
              OP_RD: begin
                is_rd_d = 1'b1;
                state_d = S_PHYAD;
              end
              OP_WR: begin
                is_rd_d = 1'b0;
                state_d = S_PHYAD;
              end
              default: begin
                state_d   = S_PRE;
                pre_cnt_d = '0;
              end
            endcase
          end
        end
        S_PHYAD: begin
          phyad_d   = {phyad_q[2:0], bit_in};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd4) begin
            ignore_d  = ({phyad_q, bit_in} != PHY_ADDR);
            bit_cnt_d = '0;
            state_d   = S_REGAD;
          end
        end
        S_REGAD: begin
          regad_d   = {regad_q[3:0], bit_in};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd4) begin
            bit_cnt_d = '0;
            state_d   = S_TA;
          end
        end
        S_TA: begin
          if (bit_cnt_q == 4'd0) begin
            bit_cnt_d = 4'd1;
            if (is_rd_q) begin
              shift_d = regs_q[regad_q];
              // Start driving the 0 the master samples as the second TA bit.
              if (!ignore_q) begin
                oe_d   = 1'b1;
                dout_d = 1'b0;
              end
            end
          end else begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
            if (is_rd_q && !ignore_q) begin
              dout_d      = shift_q[15];
              shift_d     = {shift_q[14:0], 1'b0};
              rd_d        = 1'b1;
              regad_out_d = regad_q;
            end
          end
        end
        S_DATA: begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (is_rd_q) begin
            if (bit_cnt_q == 4'd15) begin
              oe_d   = 1'b0;
              dout_d = 1'b0;
            end else if (!ignore_q) begin
              dout_d  = shift_q[15];
              shift_d = {shift_q[14:0], 1'b0};
            end
          end else begin
            shift_d = {shift_q[14:0], bit_in};
            if (bit_cnt_q == 4'd15 && !ignore_q) begin
              wr_d        = 1'b1;
              regad_out_d = regad_q;
              mdio_we     = !is_id_reg(regad_q);
            end
          end
          if (bit_cnt_q == 4'd15) begin
            state_d   = S_PRE;
            pre_cnt_d = '0;
            bit_cnt_d = '0;
`ifdef MDIO_RESP_PRESUP_EN
            if (!ignore_q) presup_d = 1'b1;
`endif
          end
        end
        default: begin
          state_d   = S_PRE;
          pre_cnt_d = '0;
        end
      endcase
    end
  end

  // Register file: local write is applied last so it wins on a collision.
  always_comb begin
    regs_d = regs_q;
    if (mdio_we) regs_d[regad_q] = mdio_wdata;
    if (lcl_we && !is_id_reg(lcl_addr)) regs_d[lcl_addr] = lcl_wdata;
    lcl_rdata_d = regs_q[lcl_addr];
  end

  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      state_q     <= S_PRE;
      pre_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      phyad_q     <= '0;
      regad_q     <= '0;
      op_hi_q     <= 1'b0;
      is_rd_q     <= 1'b0;
      ignore_q    <= 1'b0;
      oe_q        <= 1'b0;
      dout_q      <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      regad_out_q <= '0;
      lcl_rdata_q <= '0;
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
      regs_q[ID_HI_ADDR] <= PHY_ID[31:16];
      regs_q[ID_LO_ADDR] <= PHY_ID[15:0];
`ifdef MDIO_RESP_PRESUP_EN
      presup_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      op_hi_q     <= op_hi_d;
      is_rd_q     <= is_rd_d;
      ignore_q    <= ignore_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      regad_out_q <= regad_out_d;
      lcl_rdata_q <= lcl_rdata_d;
      regs_q      <= regs_d;
`ifdef MDIO_RESP_PRESUP_EN
      presup_q    <= presup_d;
`endif
    end
  end

  assign mdd_o      = dout_q;
  assign mdd_oe     = oe_q;
  assign mdio_wr    = wr_q;
  assign mdio_rd    = rd_q;
  assign mdio_regad = regad_out_q;
  assign lcl_rdata  = lcl_rdata_q;

endmodule
